// File: rtl/mmio_store_ctrl.sv
// Store-side MMIO controller: decodes CPU stores, drives the UART TX byte
// handshake and owns the cycle / retired-instruction counters.
module mmio_store_ctrl #(
  parameter logic [31:0] ADDR_UART_TX = 32'h8000_0008,
  parameter logic [31:0] ADDR_CNT_RST = 32'h8000_0018
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic [3:0]  mmio_wstrb,
  input  logic        inst_retire,
  input  logic        data_in_ready,
  output logic        data_in_valid,
  output logic [7:0]  data_in,
  output logic        tx_busy,
  output logic        stall,
  output logic [31:0] cycle_counter,
  output logic [31:0] inst_counter
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  inst_q, inst_d;

  logic tx_store;
  logic cnt_rst_store;
  logic unused_wdata;

  // Only the low byte of the store data reaches the UART.
  assign unused_wdata = ^mmio_wdata[31:8];

  assign tx_store      = (mmio_addr == ADDR_UART_TX) && mmio_wstrb[0];
  assign cnt_rst_store = (mmio_addr == ADDR_CNT_RST) && (mmio_wstrb != 4'b0000);

  // Next-state logic for the TX byte FSM.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_store) begin
          data_d  = mmio_wdata[BYTE_W-1:0];
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (data_in_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear store wins over the increment of the same cycle.
  always_comb begin
    cyc_d  = cyc_q + CNT_W'(1);
    inst_d = inst_q + CNT_W'(inst_retire);
    if (cnt_rst_store) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
    end
  end

  // The CPU holds a TX store for every cycle the previous byte is pending.
  assign stall = (state_q == ST_SEND) && tx_store;

  assign data_in_valid = (state_q == ST_SEND);
  assign tx_busy       = (state_q == ST_SEND);
  assign data_in       = data_q;
  assign cycle_counter = cyc_q;
  assign inst_counter  = inst_q;

endmodule

// File: tb/tb_mmio_store_ctrl.sv
// Directed bench for mmio_store_ctrl: TX handshake, stalls, counters, reset.
module tb_mmio_store_ctrl;

  localparam logic [31:0] A_TX  = 32'h8000_0008;
  localparam logic [31:0] A_CNT = 32'h8000_0018;
  localparam logic [31:0] A_OTH = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_wstrb;
  logic        inst_retire;
  logic        data_in_ready;
  logic        data_in_valid;
  logic [7:0]  data_in;
  logic        tx_busy;
  logic        stall;
  logic [31:0] cycle_counter;
  logic [31:0] inst_counter;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  int hs_snap;

  mmio_store_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_addr     (mmio_addr),
    .mmio_wdata    (mmio_wdata),
    .mmio_wstrb    (mmio_wstrb),
    .inst_retire   (inst_retire),
    .data_in_ready (data_in_ready),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .tx_busy       (tx_busy),
    .stall         (stall),
    .cycle_counter (cycle_counter),
    .inst_counter  (inst_counter)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && data_in_valid && data_in_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mmio_addr  = a;
    mmio_wdata = d;
    mmio_wstrb = s;
    #1;
  endtask

  task automatic no_store();
    store(32'h0, 32'h0, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; mmio_addr = '0; mmio_wdata = '0; mmio_wstrb = '0;
    inst_retire = 1'b0; data_in_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;

    // Reset state and 10 idle cycles
    check("rst_valid", 32'(data_in_valid), 32'd0);
    check("rst_data", 32'(data_in), 32'h00);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_cyc", cycle_counter, 32'd0);
    check("rst_inst", inst_counter, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("idle_cyc", cycle_counter, 32'(i));
      check("idle_inst", inst_counter, 32'd0);
      check("idle_valid", 32'(data_in_valid), 32'd0);
    end

    // Ignored stores: TX without strobe 0, other address
    store(A_TX, 32'h0000_0077, 4'b0010);
    tick();
    check("nostrb_valid", 32'(data_in_valid), 32'd0);
    store(A_OTH, 32'h0000_0066, 4'b1111);
    tick();
    check("other_valid", 32'(data_in_valid), 32'd0);
    check("other_data", 32'(data_in), 32'h00);

    // TX store with ready held high
    data_in_ready = 1'b1;
    store(A_TX, 32'h0000_0141, 4'b0001);
    check("tx1_stall", 32'(stall), 32'd0);
    tick();
    no_store();
    check("tx1_valid", 32'(data_in_valid), 32'd1);
    check("tx1_data", 32'(data_in), 32'h41);
    check("tx1_busy", 32'(tx_busy), 32'd1);
    tick();
    check("tx1_valid_off", 32'(data_in_valid), 32'd0);
    check("tx1_busy_off", 32'(tx_busy), 32'd0);
    check("tx1_data_hold", 32'(data_in), 32'h41);
    check("tx1_hs", 32'(hs_cnt), 32'd1);

    // Ready low for 5 cycles with a stalled second store of 0x42
    data_in_ready = 1'b0;
    store(A_TX, 32'h0000_0041, 4'b0001);
    tick();
    store(A_TX, 32'h0000_0042, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin data_in_ready = 1'b1; #1; end
      check("wait_valid", 32'(data_in_valid), 32'd1);
      check("wait_data", 32'(data_in), 32'h41);
      check("wait_stall", 32'(stall), 32'd1);
      if (i < 5) tick();
    end
    tick();
    check("back_idle_valid", 32'(data_in_valid), 32'd0);
    check("back_idle_stall", 32'(stall), 32'd0);
    check("wait_hs", 32'(hs_cnt), 32'd2);
    tick();
    no_store();
    check("tx2_valid", 32'(data_in_valid), 32'd1);
    check("tx2_data", 32'(data_in), 32'h42);
    tick();
    check("tx2_done", 32'(data_in_valid), 32'd0);
    check("tx2_hs", 32'(hs_cnt), 32'd3);
    data_in_ready = 1'b0;

    // inst_retire x7 then clear coinciding with a retire
    inst_retire = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("inst7", inst_counter, 32'd7);
    store(A_CNT, 32'h0, 4'b1000);
    check("clr_stall", 32'(stall), 32'd0);
    tick();
    no_store();
    inst_retire = 1'b0;
    check("clr_cyc", cycle_counter, 32'd0);
    check("clr_inst", inst_counter, 32'd0);
    check("clr_valid", 32'(data_in_valid), 32'd0);
    tick();
    check("clr_cyc1", cycle_counter, 32'd1);
    check("clr_inst1", inst_counter, 32'd0);

    // Wrap from all-ones
    force dut.cyc_q  = 32'hFFFF_FFFF;
    force dut.inst_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    release dut.inst_q;
    inst_retire = 1'b1; #1;
    check("pre_wrap_cyc", cycle_counter, 32'hFFFF_FFFF);
    tick();
    inst_retire = 1'b0;
    check("wrap_cyc", cycle_counter, 32'd0);
    check("wrap_inst", inst_counter, 32'd0);

    // Reset while in SEND discards the byte
    store(A_TX, 32'h0000_0055, 4'b0001);
    tick();
    no_store();
    check("pre_rst_valid", 32'(data_in_valid), 32'd1);
    check("pre_rst_data", 32'(data_in), 32'h55);
    rst = 1'b1;
    store(A_TX, 32'h0000_0099, 4'b0001);
    tick();
    rst = 1'b0;
    no_store();
    check("srst_valid", 32'(data_in_valid), 32'd0);
    check("srst_busy", 32'(tx_busy), 32'd0);
    check("srst_data", 32'(data_in), 32'h00);
    check("srst_cyc", cycle_counter, 32'd0);
    check("srst_inst", inst_counter, 32'd0);
    hs_snap = hs_cnt;
    data_in_ready = 1'b1;
    tick(); tick(); tick();
    check("srst_no_hs", 32'(hs_cnt), 32'(hs_snap));
    check("srst_valid_late", 32'(data_in_valid), 32'd0);
    check("srst_cyc3", cycle_counter, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
